// File: rtl/btb_target_gen.sv
`default_nettype none
// ============================================================================
// Module   : btb_target_gen
// Purpose  : EX-stage jump/branch target generation plus a direct-mapped BTB
//            with 2-bit counters for IF prediction and mispredict training.
// Revision : 1.0 - initial release
// ============================================================================
module btb_target_gen #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [XLEN-1:0]  IF_PC,
    output logic             PRED_HIT,
    output logic [XLEN-1:0]  PRED_NEXT_PC,
    input  logic             EX_VALID,
    input  logic [XLEN-1:0]  EX_PC,
    input  logic [1:0]       EX_KIND,
    input  logic             EX_TAKEN,
    input  logic [XLEN-1:0]  EX_RS1,
    input  logic [XLEN-1:0]  EX_ITYPE,
    input  logic [XLEN-1:0]  EX_JTYPE,
    input  logic [XLEN-1:0]  EX_BTYPE,
    input  logic [XLEN-1:0]  EX_PRED_NEXT_PC,
    input  logic             FLUSH_BTB,
    output logic [XLEN-1:0]  JAL,
    output logic [XLEN-1:0]  JALR,
    output logic [XLEN-1:0]  BRANCH,
    output logic [XLEN-1:0]  EX_NEXT_PC,
    output logic             EX_MISPREDICT,
    output logic [CNT_W-1:0] MISPRED_COUNT
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    localparam logic [1:0] KIND_NONE   = 2'b00;
    localparam logic [1:0] KIND_BRANCH = 2'b01;
    localparam logic [1:0] KIND_JAL    = 2'b10;
    localparam logic [1:0] KIND_JALR   = 2'b11;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [1:0]       kind_q   [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [CNT_W-1:0] count_q;

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_match;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_match;
    logic [XLEN-1:0]  ex_seq_pc;

    // Lookup reads the registered table, so a same-cycle update is not seen.
    assign if_idx   = IF_PC[IDX_W+1:2];
    assign if_tag   = IF_PC[XLEN-1:IDX_W+2];
    assign if_match = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    assign PRED_HIT     = if_match && ((kind_q[if_idx] != KIND_BRANCH) || ctr_q[if_idx][1]);
    assign PRED_NEXT_PC = PRED_HIT ? target_q[if_idx] : IF_PC + XLEN'(4);

    assign JAL       = EX_PC + EX_JTYPE;
    assign JALR      = (EX_RS1 + EX_ITYPE) & ~XLEN'(1);
    assign BRANCH    = EX_PC + EX_BTYPE;
    assign ex_seq_pc = EX_PC + XLEN'(4);

    always_comb begin
        EX_NEXT_PC = ex_seq_pc;
        case (EX_KIND)
            KIND_JAL:    EX_NEXT_PC = JAL;
            KIND_JALR:   EX_NEXT_PC = JALR;
            KIND_BRANCH: EX_NEXT_PC = EX_TAKEN ? BRANCH : ex_seq_pc;
            default:     EX_NEXT_PC = ex_seq_pc;
        endcase
    end

    assign EX_MISPREDICT = EX_VALID && (EX_NEXT_PC != EX_PRED_NEXT_PC);

    assign ex_idx   = EX_PC[IDX_W+1:2];
    assign ex_tag   = EX_PC[XLEN-1:IDX_W+2];
    assign ex_match = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (FLUSH_BTB) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (EX_VALID) begin
            case (EX_KIND)
                KIND_BRANCH: begin
                    if (ex_match) begin
                        if (EX_TAKEN) begin
                            target_q[ex_idx] <= BRANCH;
                            if (ctr_q[ex_idx] != 2'b11)
                                ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'b01;
                        end else if (ctr_q[ex_idx] != 2'b00) begin
                            ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'b01;
                        end
                    end else if (EX_TAKEN) begin
                        valid_q[ex_idx]  <= 1'b1;
                        tag_q[ex_idx]    <= ex_tag;
                        kind_q[ex_idx]   <= KIND_BRANCH;
                        target_q[ex_idx] <= BRANCH;
                        ctr_q[ex_idx]    <= 2'b10;
                    end
                end
                KIND_JAL, KIND_JALR: begin
                    valid_q[ex_idx]  <= 1'b1;
                    tag_q[ex_idx]    <= ex_tag;
                    kind_q[ex_idx]   <= EX_KIND;
                    target_q[ex_idx] <= (EX_KIND == KIND_JAL) ? JAL : JALR;
                    ctr_q[ex_idx]    <= 2'b11;
                end
                default: begin
                    if (ex_match)
                        valid_q[ex_idx] <= 1'b0;
                end
            endcase
        end
    end

    // Counts through flushes; only reset clears it.
    always_ff @(posedge CLK) begin
        if (RST)
            count_q <= '0;
        else if (EX_MISPREDICT && !(&count_q))
            count_q <= count_q + CNT_W'(1);
    end

    assign MISPRED_COUNT = count_q;

endmodule
`default_nettype wire

// File: tb/tb_btb_target_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_btb_target_gen
// Purpose  : Scoreboard bench for btb_target_gen against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btb_target_gen;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [XLEN-1:0]  IF_PC = '0;
    logic             PRED_HIT;
    logic [XLEN-1:0]  PRED_NEXT_PC;
    logic             EX_VALID = 1'b0;
    logic [XLEN-1:0]  EX_PC = '0;
    logic [1:0]       EX_KIND = 2'b00;
    logic             EX_TAKEN = 1'b0;
    logic [XLEN-1:0]  EX_RS1 = '0;
    logic [XLEN-1:0]  EX_ITYPE = '0;
    logic [XLEN-1:0]  EX_JTYPE = '0;
    logic [XLEN-1:0]  EX_BTYPE = '0;
    logic [XLEN-1:0]  EX_PRED_NEXT_PC = '0;
    logic             FLUSH_BTB = 1'b0;
    logic [XLEN-1:0]  JAL;
    logic [XLEN-1:0]  JALR;
    logic [XLEN-1:0]  BRANCH;
    logic [XLEN-1:0]  EX_NEXT_PC;
    logic             EX_MISPREDICT;
    logic [CNT_W-1:0] MISPRED_COUNT;

    always #5 CLK = ~CLK;

    btb_target_gen #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .IF_PC(IF_PC), .PRED_HIT(PRED_HIT),
        .PRED_NEXT_PC(PRED_NEXT_PC), .EX_VALID(EX_VALID), .EX_PC(EX_PC),
        .EX_KIND(EX_KIND), .EX_TAKEN(EX_TAKEN), .EX_RS1(EX_RS1),
        .EX_ITYPE(EX_ITYPE), .EX_JTYPE(EX_JTYPE), .EX_BTYPE(EX_BTYPE),
        .EX_PRED_NEXT_PC(EX_PRED_NEXT_PC), .FLUSH_BTB(FLUSH_BTB),
        .JAL(JAL), .JALR(JALR), .BRANCH(BRANCH), .EX_NEXT_PC(EX_NEXT_PC),
        .EX_MISPREDICT(EX_MISPREDICT), .MISPRED_COUNT(MISPRED_COUNT)
    );

    typedef struct {
        logic             hit;
        logic [XLEN-1:0]  pnext;
        logic [XLEN-1:0]  jal;
        logic [XLEN-1:0]  jalr;
        logic [XLEN-1:0]  br;
        logic [XLEN-1:0]  exn;
        logic             mis;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference table: entry chosen by word address modulo ENTRIES.
    bit              m_valid [ENTRIES];
    logic [XLEN-1:0] m_tag   [ENTRIES];
    logic [1:0]      m_kind  [ENTRIES];
    logic [XLEN-1:0] m_tgt   [ENTRIES];
    int              m_ctr   [ENTRIES];
    int              m_cnt = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, expv, $time);
        end
    endtask

    function automatic int idx_of(input logic [XLEN-1:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [XLEN-1:0] tag_of(input logic [XLEN-1:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic step(input bit rst, input bit flush, input logic [XLEN-1:0] ifpc,
                        input bit v, input logic [XLEN-1:0] pc, input logic [1:0] k,
                        input bit tk, input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] it,
                        input logic [XLEN-1:0] jt, input logic [XLEN-1:0] bt,
                        input logic [XLEN-1:0] pn);
        exp_t e;
        int   ii;
        int   ei;
        bit   match;
        @(posedge CLK);
        #1;
        RST = rst; FLUSH_BTB = flush; IF_PC = ifpc; EX_VALID = v; EX_PC = pc;
        EX_KIND = k; EX_TAKEN = tk; EX_RS1 = rs1; EX_ITYPE = it; EX_JTYPE = jt;
        EX_BTYPE = bt; EX_PRED_NEXT_PC = pn;

        ii = idx_of(ifpc);
        e.hit   = m_valid[ii] && m_tag[ii] == tag_of(ifpc) && (m_kind[ii] != 2'b01 || m_ctr[ii] >= 2);
        e.pnext = e.hit ? m_tgt[ii] : ifpc + 32'd4;
        e.jal   = pc + jt;
        e.jalr  = (rs1 + it) & 32'hFFFF_FFFE;
        e.br    = pc + bt;
        if (k == 2'b10)                e.exn = e.jal;
        else if (k == 2'b11)           e.exn = e.jalr;
        else if (k == 2'b01 && tk)     e.exn = e.br;
        else                           e.exn = pc + 32'd4;
        e.mis = v && (e.exn != pn);
        e.cnt = CNT_W'(m_cnt);
        if (!rst) sb.push_back(e);

        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 0;
                m_ctr[i] = 1;
            end
            m_cnt = 0;
        end else begin
            if (e.mis && m_cnt < CNT_MAX) m_cnt++;
            ei = idx_of(pc);
            match = m_valid[ei] && m_tag[ei] == tag_of(pc);
            if (flush) begin
                for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
            end else if (v) begin
                if (k == 2'b01) begin
                    if (match) begin
                        if (tk) begin
                            m_tgt[ei] = e.br;
                            if (m_ctr[ei] < 3) m_ctr[ei]++;
                        end else if (m_ctr[ei] > 0) begin
                            m_ctr[ei]--;
                        end
                    end else if (tk) begin
                        m_valid[ei] = 1; m_tag[ei] = tag_of(pc); m_kind[ei] = 2'b01;
                        m_tgt[ei] = e.br; m_ctr[ei] = 2;
                    end
                end else if (k[1]) begin
                    m_valid[ei] = 1; m_tag[ei] = tag_of(pc); m_kind[ei] = k;
                    m_tgt[ei] = (k == 2'b10) ? e.jal : e.jalr; m_ctr[ei] = 3;
                end else if (match) begin
                    m_valid[ei] = 0;
                end
            end
        end
    endtask

    task automatic idle(input logic [XLEN-1:0] ifpc);
        step(0, 0, ifpc, 0, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are combinational, sampled mid-cycle on the falling edge.
    always @(negedge CLK) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pred_hit",   {31'b0, PRED_HIT},      {31'b0, e.hit});
            chk("pred_next",  PRED_NEXT_PC,           e.pnext);
            chk("jal",        JAL,                    e.jal);
            chk("jalr",       JALR,                   e.jalr);
            chk("branch",     BRANCH,                 e.br);
            chk("ex_next_pc", EX_NEXT_PC,             e.exn);
            chk("mispredict", {31'b0, EX_MISPREDICT}, {31'b0, e.mis});
            chk("mis_count",  {28'b0, MISPRED_COUNT}, {28'b0, e.cnt});
        end
    end

    function automatic logic [XLEN-1:0] rand_pc();
        return (XLEN'($urandom_range(0, 3)) << 6) | (XLEN'($urandom_range(0, ENTRIES-1)) << 2);
    endfunction

    initial begin
        logic [XLEN-1:0] pc, ifpc, rs1, it, jt, bt, pn;
        logic [1:0]      k;
        int              sel;
        int              wait_cycles;

        step(1, 0, 32'h100, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        step(1, 0, 32'h100, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        idle(32'h100);
        // First taken branch allocates and mispredicts.
        step(0, 0, 32'h100, 1, 32'h100, 2'b01, 1, 0, 0, 0, 32'h40, 32'h104);
        idle(32'h100);
        step(0, 0, 32'h180, 1, 32'h100, 2'b01, 0, 0, 0, 0, 32'h40, 32'h140);
        step(0, 0, 32'h180, 1, 32'h100, 2'b01, 0, 0, 0, 0, 32'h40, 32'h104);
        idle(32'h100);
        for (int i = 0; i < 3; i++)
            step(0, 0, 32'h100, 1, 32'h100, 2'b01, 1, 0, 0, 0, 32'h40, 32'h104);
        idle(32'h100);
        // JALR at index 0, then aliasing fetch with a different tag.
        step(0, 0, 32'h200, 1, 32'h0, 2'b11, 0, 32'h2001, 32'h4, 0, 0, 32'h4);
        idle(32'h200);
        idle(32'h0);
        // Read-before-write on the same index.
        step(0, 0, 32'h300, 1, 32'h300, 2'b10, 0, 0, 0, 32'h1000, 0, 32'h304);
        idle(32'h300);
        // Flush drops the concurrent update.
        step(0, 1, 32'h300, 1, 32'h340, 2'b10, 0, 0, 0, 32'h80, 0, 32'h344);
        idle(32'h300);
        idle(32'h340);
        idle(32'h100);
        idle(32'h0);
        // Counter saturation and PC+4 wrap.
        for (int i = 0; i < 20; i++)
            step(0, 0, 32'h0, 1, 32'h40, 2'b00, 0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 2'b00, 0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 32'h0, 0, 32'h40, 2'b00, 0, 0, 0, 0, 0, 32'h0);

        step(1, 0, 32'h0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            pc   = rand_pc();
            ifpc = ($urandom_range(0, 1) == 1) ? pc : rand_pc();
            k    = 2'($urandom_range(0, 3));
            rs1  = $urandom;
            it   = XLEN'($signed(12'($urandom)));
            jt   = XLEN'($signed(13'($urandom))) & ~32'h1;
            bt   = XLEN'($signed(13'($urandom))) & ~32'h1;
            sel  = $urandom_range(0, 3);
            case (sel)
                0:       pn = pc + 32'd4;
                1:       pn = pc + bt;
                2:       pn = pc + jt;
                default: pn = (rs1 + it) & 32'hFFFF_FFFE;
            endcase
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0), ifpc,
                 ($urandom_range(0, 7) != 0), pc, k, $urandom_range(0, 1) == 1,
                 rs1, it, jt, bt, pn);
        end
        idle(32'h0);

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge CLK);
            wait_cycles++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
